// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single rf_32 write port among NUM_REQ writeback sources.
// Latency: req sampled at edge N -> ack and write port outputs registered after edge N.
// Backpressure: hold freezes all grants; an unacked req stays pending until granted.
module rf_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int DROP_R0 = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       hold,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       write_enabled,
    output logic [ADDR_W-1:0]          write_addr,
    output logic [DATA_W-1:0]          write_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   gid_q, gid_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   sel;
    int                 idx;

    // A source whose ack is high this cycle has been consumed; ignore its req.
    assign eligible = req & ~ack_q;
    assign busy     = |eligible;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDX_W'(idx);
            if (!found && eligible[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    always_comb begin
        ack_d  = '0;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        ptr_d  = ptr_q;
        if (!hold && found) begin
            ack_d[winner] = 1'b1;
            gid_d         = winner;
            ptr_d         = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
            addr_d        = req_addr[int'(winner)*ADDR_W +: ADDR_W];
            data_d        = req_data[int'(winner)*DATA_W +: DATA_W];
            // R0 writes are still acked so the source retires, just never reach rf_32.
            we_d          = !((DROP_R0 != 0) && (addr_d == '0));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
            ptr_q  <= '0;
        end else begin
            ack_q  <= ack_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            ptr_q  <= ptr_d;
        end
    end

    assign ack           = ack_q;
    assign write_enabled = we_q;
    assign write_addr    = addr_q;
    assign write_data    = data_q;
    assign grant_id      = gid_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: vector table through a scoreboard queue, plus R0-drop and reset sequences.
module tb_rf_write_arbiter;

    localparam logic [31:0] D0 = 32'hA0A0_0001;
    localparam logic [31:0] D1 = 32'hB1B1_0002;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'hC3C3_0004;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         hold;
    logic [3:0]   req;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   ack;
    logic         write_enabled;
    logic [4:0]   write_addr;
    logic [31:0]  write_data;
    logic [1:0]   grant_id;
    logic         busy;

    logic         hold2;
    logic [3:0]   req2;
    logic [19:0]  req_addr2;
    logic [127:0] req_data2;
    logic [3:0]   ack2;
    logic         we2;
    logic [4:0]   waddr2;
    logic [31:0]  wdata2;
    logic [1:0]   gid2;
    logic         busy2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rf_write_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32), .DROP_R0(0)) dut (
        .clock(clock), .reset_n(reset_n), .hold(hold), .req(req),
        .req_addr(req_addr), .req_data(req_data), .ack(ack),
        .write_enabled(write_enabled), .write_addr(write_addr),
        .write_data(write_data), .grant_id(grant_id), .busy(busy)
    );

    rf_write_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32), .DROP_R0(1)) dut_r0 (
        .clock(clock), .reset_n(reset_n), .hold(hold2), .req(req2),
        .req_addr(req_addr2), .req_data(req_data2), .ack(ack2),
        .write_enabled(we2), .write_addr(waddr2),
        .write_data(wdata2), .grant_id(gid2), .busy(busy2)
    );

    // Register file models standing in for rf_32 behind each arbiter.
    logic [31:0] rf1 [32];
    logic [31:0] rf2 [32];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                rf1[i] <= '0;
                rf2[i] <= '0;
            end
        end else begin
            if (write_enabled) rf1[write_addr] <= write_data;
            if (we2) rf2[waddr2] <= wdata2;
        end
    end

    typedef struct {
        logic        hold;
        logic [3:0]  req;
        logic        busy;
        logic [3:0]  ack;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  gid;
    } vec_t;

    typedef struct {
        logic [3:0]  ack;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  gid;
    } exp_t;

    vec_t vecs [25];
    exp_t sbq [$];

    function automatic vec_t mk(input logic h, input logic [3:0] r, input logic b,
                                input logic [3:0] a, input logic w, input logic [4:0] ad,
                                input logic [31:0] d, input logic [1:0] g);
        vec_t v;
        v.hold = h; v.req = r; v.busy = b; v.ack = a;
        v.we = w; v.addr = ad; v.data = d; v.gid = g;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t e;

        // Round robin from reset, then single source, back-to-back, hold, hold-during-ack.
        vecs[0]  = mk(0, 4'b1111, 1, 4'b0001, 1, 5'd1, D0, 2'd0);
        vecs[1]  = mk(0, 4'b1111, 1, 4'b0010, 1, 5'd3, D1, 2'd1);
        vecs[2]  = mk(0, 4'b1111, 1, 4'b0100, 1, 5'd5, D2, 2'd2);
        vecs[3]  = mk(0, 4'b1111, 1, 4'b1000, 1, 5'd9, D3, 2'd3);
        vecs[4]  = mk(0, 4'b1111, 1, 4'b0001, 1, 5'd1, D0, 2'd0);
        vecs[5]  = mk(0, 4'b0000, 0, 4'b0000, 0, 5'd1, D0, 2'd0);
        vecs[6]  = mk(0, 4'b0100, 1, 4'b0100, 1, 5'd5, D2, 2'd2);
        vecs[7]  = mk(0, 4'b0100, 0, 4'b0000, 0, 5'd5, D2, 2'd2);
        vecs[8]  = mk(0, 4'b0000, 0, 4'b0000, 0, 5'd5, D2, 2'd2);
        vecs[9]  = mk(0, 4'b0010, 1, 4'b0010, 1, 5'd3, D1, 2'd1);
        vecs[10] = mk(0, 4'b0010, 0, 4'b0000, 0, 5'd3, D1, 2'd1);
        vecs[11] = mk(0, 4'b0010, 1, 4'b0010, 1, 5'd3, D1, 2'd1);
        vecs[12] = mk(0, 4'b0010, 0, 4'b0000, 0, 5'd3, D1, 2'd1);
        vecs[13] = mk(0, 4'b0000, 0, 4'b0000, 0, 5'd3, D1, 2'd1);
        vecs[14] = mk(1, 4'b0011, 1, 4'b0000, 0, 5'd3, D1, 2'd1);
        vecs[15] = mk(1, 4'b0011, 1, 4'b0000, 0, 5'd3, D1, 2'd1);
        vecs[16] = mk(1, 4'b0011, 1, 4'b0000, 0, 5'd3, D1, 2'd1);
        vecs[17] = mk(0, 4'b0011, 1, 4'b0001, 1, 5'd1, D0, 2'd0);
        vecs[18] = mk(0, 4'b0011, 1, 4'b0010, 1, 5'd3, D1, 2'd1);
        vecs[19] = mk(0, 4'b0010, 0, 4'b0000, 0, 5'd3, D1, 2'd1);
        vecs[20] = mk(0, 4'b0000, 0, 4'b0000, 0, 5'd3, D1, 2'd1);
        vecs[21] = mk(0, 4'b0100, 1, 4'b0100, 1, 5'd5, D2, 2'd2);
        vecs[22] = mk(1, 4'b1100, 1, 4'b0000, 0, 5'd5, D2, 2'd2);
        vecs[23] = mk(0, 4'b1000, 1, 4'b1000, 1, 5'd9, D3, 2'd3);
        vecs[24] = mk(0, 4'b0000, 0, 4'b0000, 0, 5'd9, D3, 2'd3);

        reset_n   = 1'b0;
        hold      = 1'b0;
        req       = '0;
        req_addr  = {5'd9, 5'd5, 5'd3, 5'd1};
        req_data  = {D3, D2, D1, D0};
        hold2     = 1'b0;
        req2      = '0;
        req_addr2 = '0;
        req_data2 = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_we", 64'(write_enabled), 64'h0);
        chk("rst_addr", 64'(write_addr), 64'h0);
        chk("rst_data", 64'(write_data), 64'h0);
        chk("rst_gid", 64'(grant_id), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            hold = vecs[i].hold;
            req  = vecs[i].req;
            #1;
            chk($sformatf("busy[%0d]", i), 64'(busy), 64'(vecs[i].busy));
            e.ack = vecs[i].ack; e.we = vecs[i].we; e.addr = vecs[i].addr;
            e.data = vecs[i].data; e.gid = vecs[i].gid;
            sbq.push_back(e);
            @(posedge clock);
            #1;
            if (sbq.size() == 0) begin
                chk($sformatf("sb_empty[%0d]", i), 64'd0, 64'd1);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("ack[%0d]", i), 64'(ack), 64'(e.ack));
                chk($sformatf("we[%0d]", i), 64'(write_enabled), 64'(e.we));
                chk($sformatf("addr[%0d]", i), 64'(write_addr), 64'(e.addr));
                chk($sformatf("data[%0d]", i), 64'(write_data), 64'(e.data));
                chk($sformatf("gid[%0d]", i), 64'(grant_id), 64'(e.gid));
            end
        end

        @(negedge clock);
        chk("rf1[1]", 64'(rf1[1]), 64'(D0));
        chk("rf1[3]", 64'(rf1[3]), 64'(D1));
        chk("rf1[5]", 64'(rf1[5]), 64'(D2));
        chk("rf1[9]", 64'(rf1[9]), 64'(D3));

        // R0 drop: acked but not written; the next write from the same source lands.
        req2      = 4'b1000;
        req_addr2 = {5'd0, 15'd0};
        req_data2 = {32'h1234_5678, 96'd0};
        @(posedge clock);
        #1;
        chk("r0_ack", 64'(ack2), 64'b1000);
        chk("r0_we", 64'(we2), 64'h0);
        chk("r0_addr", 64'(waddr2), 64'h0);
        chk("r0_data", 64'(wdata2), 64'h1234_5678);
        @(posedge clock);
        #1;
        chk("r0_ack_gap", 64'(ack2), 64'h0);
        @(negedge clock);
        req_addr2 = {5'd1, 15'd0};
        req_data2 = {32'h0000_5555, 96'd0};
        #1;
        chk("r0_busy", 64'(busy2), 64'h1);
        @(posedge clock);
        #1;
        chk("r1_ack", 64'(ack2), 64'b1000);
        chk("r1_we", 64'(we2), 64'h1);
        chk("r1_addr", 64'(waddr2), 64'h1);
        @(negedge clock);
        req2 = '0;
        @(negedge clock);
        chk("rf2[0]", 64'(rf2[0]), 64'h0);
        chk("rf2[1]", 64'(rf2[1]), 64'h5555);

        // Asynchronous reset in the middle of a grant.
        req = 4'b1111;
        @(posedge clock);
        #1;
        chk("pre_rst_ack", 64'(ack), 64'b0001);
        chk("pre_rst_we", 64'(write_enabled), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ack", 64'(ack), 64'h0);
        chk("mid_rst_we", 64'(write_enabled), 64'h0);
        chk("mid_rst_addr", 64'(write_addr), 64'h0);
        chk("mid_rst_gid", 64'(grant_id), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_ack", 64'(ack), 64'b0001);
        chk("post_rst_gid", 64'(grant_id), 64'h0);
        chk("post_rst_addr", 64'(write_addr), 64'd1);
        @(negedge clock);
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
